sg_divider: RTL and testbench



---
 rtl/sg_divider.sv | 132 +++++++++++++
 tb/tb_sg_divider.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sg_divider.sv
// sg_divider: restoring significand divider, Q = floor(A*2^(Q_W-1)/B), one quotient bit per clock plus sticky.
// Latency Q_W+1 (error path 2); result held until out_ready; no new operands while busy. Option: SG_DIV_EARLY_TERM_EN.
module sg_divider #(
  parameter int SG_W = 11,
  parameter int Q_W  = 13
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SG_W-1:0] in_sg_A,
  input  logic [SG_W-1:0] in_sg_B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Q_W-1:0]  quotient,
  output logic            sticky,
  output logic            div_err
);

  localparam int CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SG_W:0]   r_rem;
  logic [SG_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [Q_W-1:0]  r_quot;
  logic            r_sticky;
  logic            r_err;

  logic            w_ge;
  logic [SG_W:0]   w_r;
  logic            w_last;

  assign w_ge = (r_rem >= {1'b0, r_div});
  assign w_r  = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

`ifdef SG_DIV_EARLY_TERM_EN
  // Zero partial remainder: all remaining quotient bits are already 0.
  assign w_last = (r_cnt == '0) || (w_r == '0);
`else
  assign w_last = (r_cnt == '0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Error path spends one RUN cycle doing nothing so its result lands at T+2.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = RUN;
      RUN:     if (r_err || w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rem    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_sticky <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_div    <= in_sg_B;
            r_sticky <= 1'b0;
            if (in_sg_B[SG_W-1]) begin
              r_rem  <= {1'b0, in_sg_A};
              r_cnt  <= CNT_W'(Q_W - 1);
              r_quot <= '0;
              r_err  <= 1'b0;
            end else begin
              r_cnt  <= '0;
              r_quot <= '1;
              r_err  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!r_err) begin
            r_quot[r_cnt] <= w_ge;
            if (w_last) begin
              r_rem    <= w_r;
              r_sticky <= (w_r != '0);
            end else begin
              // w_r < B < 2^SG_W, so the shift cannot lose a bit.
              r_rem <= {w_r[SG_W-1:0], 1'b0};
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient = r_quot;
  assign sticky   = r_sticky;
  assign div_err  = r_err;

endmodule

// File: tb/tb_sg_divider.sv
// Bench for sg_divider: directed vector table, hold/abort sequences, then random operands against an arithmetic model.
module tb_sg_divider;

  localparam int SG_W = 11;
  localparam int Q_W  = 13;
`ifdef SG_DIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [SG_W-1:0] in_sg_A;
  logic [SG_W-1:0] in_sg_B;
  logic            out_valid;
  logic            out_ready;
  logic [Q_W-1:0]  quotient;
  logic            sticky;
  logic            div_err;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  sg_divider #(.SG_W(SG_W), .Q_W(Q_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sg_A   (in_sg_A),
    .in_sg_B   (in_sg_B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .sticky    (sticky),
    .div_err   (div_err)
  );

  typedef struct {
    logic [SG_W-1:0] a;
    logic [SG_W-1:0] b;
    logic [Q_W-1:0]  q;
    logic            s;
    logic            e;
    int              lat_full;
    int              lat_early;
    int              hold;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact rational arithmetic on the operands, latency from the first zero partial remainder.
  function automatic void model(input logic [SG_W-1:0] a, input logic [SG_W-1:0] b,
                                output logic [Q_W-1:0] q, output logic s, output logic e,
                                output int lat);
    longint num;
    num = longint'(a) << (Q_W - 1);
    if (!b[SG_W-1]) begin
      q   = '1;
      s   = 1'b0;
      e   = 1'b1;
      lat = 2;
    end else begin
      q   = Q_W'(num / longint'(b));
      s   = ((num % longint'(b)) != 0);
      e   = 1'b0;
      lat = Q_W + 1;
      if (EARLY) begin
        for (int k = 1; k <= Q_W; k++) begin
          if (((longint'(a) << (k - 1)) % longint'(b)) == 0) begin
            lat = k + 1;
            break;
          end
        end
      end
    end
  endfunction

  task automatic do_div(input logic [SG_W-1:0] a, input logic [SG_W-1:0] b, input int hold,
                        output logic [Q_W-1:0] q, output logic s, output logic e, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_sg_A  = a;
    in_sg_B  = b;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      in_sg_A = SG_W'($urandom);
      in_sg_B = SG_W'($urandom);
      @(negedge clock);
      lat++;
    end
    q = quotient;
    s = sticky;
    e = div_err;
    chk("in_ready_in_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_sg_A  = SG_W'($urandom);
      in_sg_B  = SG_W'($urandom);
      @(negedge clock);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_quotient", 32'(quotient), 32'(q));
      chk("hold_sticky", 32'(sticky), 32'(s));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("out_valid_released", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [Q_W-1:0] q, mq;
    logic           s, e, ms, me;
    int             lat, mlat, seen;
    logic [SG_W-1:0] ra, rb;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_sg_A   = '0;
    in_sg_B   = '0;

    vecs[0] = '{a:11'h123, b:11'h000, q:13'h1FFF, s:1'b0, e:1'b1, lat_full:2,  lat_early:2,  hold:0};
    vecs[1] = '{a:11'h7FF, b:11'h3FF, q:13'h1FFF, s:1'b0, e:1'b1, lat_full:2,  lat_early:2,  hold:0};
    vecs[2] = '{a:11'h400, b:11'h400, q:13'h1000, s:1'b0, e:1'b0, lat_full:14, lat_early:2,  hold:0};
    vecs[3] = '{a:11'h400, b:11'h600, q:13'h0AAA, s:1'b1, e:1'b0, lat_full:14, lat_early:14, hold:5};
    vecs[4] = '{a:11'h7FF, b:11'h400, q:13'h1FFC, s:1'b0, e:1'b0, lat_full:14, lat_early:12, hold:0};
    vecs[5] = '{a:11'h600, b:11'h400, q:13'h1800, s:1'b0, e:1'b0, lat_full:14, lat_early:3,  hold:1};

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    chk("rst_div_err", 32'(div_err), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].hold, q, s, e, lat);
      chk("vec_quotient", 32'(q), 32'(vecs[i].q));
      chk("vec_sticky", 32'(s), 32'(vecs[i].s));
      chk("vec_div_err", 32'(e), 32'(vecs[i].e));
      chk("vec_latency", 32'(lat), 32'(EARLY ? vecs[i].lat_early : vecs[i].lat_full));
    end

    // Abort a division with reset while cnt==6.
    in_sg_A  = 11'h400;
    in_sg_B  = 11'h600;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_quotient", 32'(quotient), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    do_div(11'h7FF, 11'h400, 0, q, s, e, lat);
    model(11'h7FF, 11'h400, mq, ms, me, mlat);
    chk("post_abort_quotient", 32'(q), 32'(mq));
    chk("post_abort_sticky", 32'(s), 32'(ms));
    chk("post_abort_latency", 32'(lat), 32'(mlat));

    for (int i = 0; i < 40; i++) begin
      ra = SG_W'($urandom_range(0, 2047));
      if ($urandom_range(0, 7) == 0) rb = SG_W'($urandom_range(0, 2047));
      else                           rb = SG_W'($urandom_range(1024, 2047));
      do_div(ra, rb, int'($urandom_range(0, 2)), q, s, e, lat);
      model(ra, rb, mq, ms, me, mlat);
      chk("rnd_quotient", 32'(q), 32'(mq));
      chk("rnd_sticky", 32'(s), 32'(ms));
      chk("rnd_div_err", 32'(e), 32'(me));
      chk("rnd_latency", 32'(lat), 32'(mlat));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
